// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response and fetch-to-decode handshake bundle.
// master is the fetch controller; slave is the memory/decode side.
interface fetch_ctrl_if;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        imem_err;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [63:0] if_pc;

   modport master (
      output imem_req, imem_addr, if_valid, if_instr, if_pc,
      input  imem_ack, imem_rdata, imem_err, if_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_instr, if_pc,
      output imem_ack, imem_rdata, imem_err, if_ready
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, single-entry instruction
// buffer, redirect handling with kill of in-flight responses, and a sticky fault state.
module fetch_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [63:0]         pc,
   output logic [63:0]         pc_next,
   output logic                pc_write_enable,
   input  logic                redirect_valid,
   input  logic [63:0]         redirect_target,
   input  logic                stall,
   output logic                fetch_fault,
   fetch_ctrl_if.master        bus
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StReq, StHold, StFault} state_e;

   state_e            state_q;
   logic              kill_q;
   logic [CntW-1:0]   wait_cnt_q;
   logic [63:0]       imem_addr_q;
   logic [31:0]       if_instr_q;
   logic [63:0]       if_pc_q;

   logic              active;
   logic              redirect_ok;
   logic              redirect_bad;
   logic              ack_good;
   logic              handshake;
   logic [CntW-1:0]   wait_cnt_inc;
   logic              timeout;

   assign active       = (state_q != StFault);
   assign redirect_ok  = active && redirect_valid && (redirect_target[1:0] == 2'b00);
   assign redirect_bad = active && redirect_valid && (|redirect_target[1:0]);
   assign ack_good     = (state_q == StReq) && bus.imem_ack && !kill_q && !bus.imem_err;

   // Saturate so a long run of redirect-killed cycles cannot wrap the counter.
   assign wait_cnt_inc = (wait_cnt_q == CntW'(TIMEOUT_CYCLES)) ? wait_cnt_q
                                                               : wait_cnt_q + CntW'(1);
   assign timeout      = (wait_cnt_inc >= CntW'(TIMEOUT_CYCLES));

   always_comb begin
      pc_write_enable = 1'b0;
      pc_next         = pc;
      if (redirect_ok) begin
         pc_write_enable = 1'b1;
         pc_next         = redirect_target;
      end else if (ack_good && !redirect_valid) begin
         pc_write_enable = 1'b1;
         pc_next         = pc + 64'd4;
      end
   end

   assign bus.imem_req  = (state_q == StReq);
   assign bus.imem_addr = imem_addr_q;
   assign bus.if_valid  = (state_q == StHold) && !redirect_valid;
   assign bus.if_instr  = if_instr_q;
   assign bus.if_pc     = if_pc_q;
   assign fetch_fault   = (state_q == StFault);

   assign handshake = bus.if_valid && bus.if_ready && !stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         kill_q      <= 1'b0;
         wait_cnt_q  <= '0;
         imem_addr_q <= '0;
         if_instr_q  <= '0;
         if_pc_q     <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (redirect_bad) begin
                  state_q <= StFault;
               end else begin
                  state_q     <= StReq;
                  imem_addr_q <= redirect_ok ? redirect_target : pc;
                  kill_q      <= 1'b0;
                  wait_cnt_q  <= '0;
               end
            end
            StReq: begin
               if (redirect_bad) begin
                  state_q <= StFault;
               end else if (redirect_ok) begin
                  if (bus.imem_ack) begin
                     imem_addr_q <= redirect_target;
                     kill_q      <= 1'b0;
                     wait_cnt_q  <= '0;
                  end else begin
                     // Address must stay stable; the stale response is dropped on arrival.
                     kill_q     <= 1'b1;
                     wait_cnt_q <= wait_cnt_inc;
                  end
               end else if (bus.imem_ack) begin
                  if (kill_q) begin
                     imem_addr_q <= pc;
                     kill_q      <= 1'b0;
                     wait_cnt_q  <= '0;
                  end else if (bus.imem_err) begin
                     state_q <= StFault;
                  end else begin
                     if_instr_q <= bus.imem_rdata;
                     if_pc_q    <= imem_addr_q;
                     state_q    <= StHold;
                  end
               end else if (timeout) begin
                  state_q <= StFault;
               end else begin
                  wait_cnt_q <= wait_cnt_inc;
               end
            end
            StHold: begin
               if (redirect_bad) begin
                  state_q <= StFault;
               end else if (redirect_ok) begin
                  state_q     <= StReq;
                  imem_addr_q <= redirect_target;
                  kill_q      <= 1'b0;
                  wait_cnt_q  <= '0;
               end else if (handshake) begin
                  state_q     <= StReq;
                  imem_addr_q <= pc;
                  kill_q      <= 1'b0;
                  wait_cnt_q  <= '0;
               end
            end
            StFault: begin
               state_q <= StFault;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
